// File: rtl/apb_bus_arbiter_if.sv
// APB bus bundle between the arbiter (master side) and the shared APB slave.
// Widths must match the arbiter instance that drives it.
interface apb_bus_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);

  logic                  PSELx;
  logic                  PENABLE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;

  modport master (
    output PSELx,
    output PENABLE,
    output PADDR,
    output PWRITE,
    output PWDATA,
    input  PRDATA,
    input  PREADY
  );

  modport slave (
    input  PSELx,
    input  PENABLE,
    input  PADDR,
    input  PWRITE,
    input  PWDATA,
    output PRDATA,
    output PREADY
  );

endinterface

// File: rtl/apb_bus_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ local requesters onto one APB slave,
// one IDLE/SETUP/ACCESS transfer at a time, with a PREADY timeout.
module apb_bus_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REQ    = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  apb_bus_arbiter_if.master             apb
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_RESET  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  logic                  any_valid;
  logic [IDX_W-1:0]      win_idx;
  logic [IDX_W-1:0]      cand_idx;
  logic                  grant_en;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Search starts just after the last winner so every requester waits at most NUM_REQ-1 grants.
  always_comb begin
    any_valid = 1'b0;
    win_idx   = last_q;
    cand_idx  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand_idx = IDX_W'((int'(last_q) + off) % NUM_REQ);
      if (!any_valid && req_valid[cand_idx]) begin
        any_valid = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    grant_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        grant_en  = 1'b1;
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end

      ST_ACCESS: begin
        if (apb.PREADY) begin
          rsp_valid_d[last_q] = 1'b1;
          rsp_rdata_d         = pwrite_q ? '0 : apb.PRDATA;
          cnt_d               = '0;
          state_d             = ST_IDLE;
          psel_d              = 1'b0;
          penable_d           = 1'b0;
          grant_en            = 1'b1;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          // Abort never re-arbitrates in the same cycle; the bus idles for one cycle first.
          rsp_valid_d[last_q] = 1'b1;
          rsp_err_d           = 1'b1;
          cnt_d               = '0;
          state_d             = ST_IDLE;
          psel_d              = 1'b0;
          penable_d           = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        cnt_d     = '0;
      end
    endcase

    if (grant_en && any_valid) begin
      state_d              = ST_SETUP;
      psel_d               = 1'b1;
      penable_d            = 1'b0;
      last_d               = win_idx;
      paddr_d              = addr_arr[win_idx];
      pwrite_d             = req_write[win_idx];
      pwdata_d             = wdata_arr[win_idx];
      req_ready_d[win_idx] = 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      last_q      <= LAST_RESET;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign apb.PSELx   = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Bench for apb_bus_arbiter: timeline-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_apb_bus_arbiter;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NR = 2;
  localparam int TO = 15;

  logic            PCLK      = 1'b0;
  logic            PRESET    = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_write = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;

  apb_bus_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) apb ();

  apb_bus_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .TIMEOUT(TO)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .apb       (apb)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Slave: PREADY rises after ws wait cycles of each ACCESS phase.
  int            ws = 0;
  int            acc = 0;
  logic [DW-1:0] slave_rdata = '0;
  always @(negedge PCLK) begin
    if (apb.PSELx && apb.PENABLE) begin
      apb.PREADY = (acc >= ws);
      acc++;
    end else begin
      apb.PREADY = 1'b0;
      acc = 0;
    end
    apb.PRDATA = slave_rdata;
  end

  // Reference model: a transfer granted at edge t_grant is in SETUP until the next edge,
  // then the j-th ACCESS cycle is resolved at edge t_grant+1+j.
  int            edge_n = 0, t_grant = 0, cur = 0, m_last = NR - 1, m_idx = 0;
  bit            active = 1'b0, model_ok = 1'b0, cur_write = 1'b0;
  logic [NR-1:0] e_ready = '0, e_rspv = '0;
  logic [DW-1:0] e_rdata = '0, e_pwdata = '0;
  logic [AW-1:0] e_paddr = '0;
  logic          e_err = 1'b0, e_psel = 1'b0, e_pen = 1'b0, e_pwrite = 1'b0;

  always @(posedge PCLK) begin
    bit can_grant;
    bit found;
    int j;
    edge_n++;
    e_ready = '0;
    e_rspv  = '0;
    e_err   = 1'b0;
    e_rdata = '0;
    if (PRESET) begin
      model_ok = 1'b1;
      active   = 1'b0;
      m_last   = NR - 1;
      e_psel   = 1'b0;
      e_pen    = 1'b0;
      e_paddr  = '0;
      e_pwrite = 1'b0;
      e_pwdata = '0;
    end else if (model_ok) begin
      j = edge_n - t_grant - 1;
      can_grant = !active;
      if (active && j >= 1) begin
        if (apb.PREADY) begin
          e_rspv[cur] = 1'b1;
          e_rdata     = cur_write ? '0 : apb.PRDATA;
          active      = 1'b0;
          can_grant   = 1'b1;
        end else if (j == TO) begin
          e_rspv[cur] = 1'b1;
          e_err       = 1'b1;
          active      = 1'b0;
        end
      end
      if (can_grant) begin
        found = 1'b0;
        for (int k = 1; k <= NR; k++) begin
          m_idx = (m_last + k) % NR;
          if (!found && req_valid[m_idx]) begin
            found     = 1'b1;
            cur       = m_idx;
          end
        end
        if (found) begin
          active       = 1'b1;
          t_grant      = edge_n;
          m_last       = cur;
          cur_write    = req_write[cur];
          e_paddr      = req_addr[cur*AW +: AW];
          e_pwrite     = req_write[cur];
          e_pwdata     = req_wdata[cur*DW +: DW];
          e_ready[cur] = 1'b1;
        end
      end
      e_psel = active;
      e_pen  = active && (edge_n != t_grant);
    end
  end

  // Compare + event monitor, half a cycle after each active edge.
  int cyc = 0, psel_cnt = 0, pen_cnt = 0, rsp_cnt = 0;
  int grants[$];
  int grant_cyc[$];
  always @(negedge PCLK) begin
    cyc++;
    if (model_ok) begin
      chk("cmp_req_ready", req_ready, e_ready);
      chk("cmp_rsp_valid", rsp_valid, e_rspv);
      if (e_rspv != '0) begin
        chk("cmp_rsp_err", rsp_err, e_err);
        chk("cmp_rsp_rdata", rsp_rdata, e_rdata);
      end
      chk("cmp_psel", apb.PSELx, e_psel);
      chk("cmp_penable", apb.PENABLE, e_pen);
      chk("cmp_paddr", apb.PADDR, e_paddr);
      chk("cmp_pwrite", apb.PWRITE, e_pwrite);
      chk("cmp_pwdata", apb.PWDATA, e_pwdata);
    end
    if (apb.PSELx === 1'b1)   psel_cnt++;
    if (apb.PENABLE === 1'b1) pen_cnt++;
    if (rsp_valid != '0)      rsp_cnt++;
    for (int i = 0; i < NR; i++) begin
      if (req_ready[i] === 1'b1) begin
        grants.push_back(i);
        grant_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(negedge PCLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_write[i]          = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic wait_ready(input int i);
    int n = 0;
    while (req_ready[i] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk($sformatf("ready%0d_seen", i), req_ready[i], 1'b1);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int i, output logic [DW-1:0] rd, output logic er, output logic ps);
    int n = 0;
    do begin
      tick();
      n++;
    end while (rsp_valid[i] !== 1'b1 && n < 40);
    chk($sformatf("rsp%0d_seen", i), rsp_valid[i], 1'b1);
    rd = rsp_rdata;
    er = rsp_err;
    ps = apb.PSELx;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] rd;
    logic          er, ps;
    int            b_psel, b_pen, b_g, b_rsp, t_rsp, n;
    int            exp_order [4] = '{0, 1, 0, 1};

    repeat (3) tick();
    chk("rst_psel", apb.PSELx, 1'b0);
    chk("rst_penable", apb.PENABLE, 1'b0);
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_rsp", rsp_valid, 2'b00);
    PRESET = 1'b0;

    // Single write from requester 0, zero wait states
    ws = 0;
    b_psel = psel_cnt; b_pen = pen_cnt;
    set_req(0, 1'b1, 4'h3, 8'hA5);
    wait_ready(0);
    chk("t1_paddr", apb.PADDR, 4'h3);
    chk("t1_pwrite", apb.PWRITE, 1'b1);
    chk("t1_pwdata", apb.PWDATA, 8'hA5);
    chk("t1_setup_pen", apb.PENABLE, 1'b0);
    wait_rsp(0, rd, er, ps);
    chk("t1_err", er, 1'b0);
    chk("t1_rdata", rd, 8'h00);
    tick(); tick();
    chk("t1_psel_cycles", psel_cnt - b_psel, 2);
    chk("t1_pen_cycles", pen_cnt - b_pen, 1);
    $display("t1 write req0 addr=3 data=a5 done");

    // Read from requester 1 with 2 wait states
    ws = 2; slave_rdata = 8'h5A;
    b_pen = pen_cnt;
    set_req(1, 1'b0, 4'h3, 8'h00);
    wait_ready(1);
    wait_rsp(1, rd, er, ps);
    chk("t2_rdata", rd, 8'h5A);
    chk("t2_err", er, 1'b0);
    tick();
    chk("t2_pen_cycles", pen_cnt - b_pen, 3);
    $display("t2 read req1 addr=3 rdata=%0h", rd);

    // Contention: both requesters held high for four grants
    ws = 0; slave_rdata = 8'h77;
    b_g = grants.size(); b_psel = psel_cnt; b_pen = pen_cnt; b_rsp = rsp_cnt;
    set_req(0, 1'b0, 4'h1, 8'h00);
    set_req(1, 1'b0, 4'h2, 8'h00);
    n = 0;
    while (grants.size() - b_g < 4 && n < 60) begin
      tick();
      n++;
    end
    req_valid = '0;
    repeat (4) tick();
    chk("t3_grant_count", grants.size() - b_g, 4);
    for (int k = 0; k < 4; k++) begin
      if (b_g + k < grants.size()) chk($sformatf("t3_order%0d", k), grants[b_g + k], exp_order[k]);
      if (k > 0 && b_g + k < grant_cyc.size())
        chk($sformatf("t3_gap%0d", k), grant_cyc[b_g + k] - grant_cyc[b_g + k - 1], 2);
    end
    chk("t3_psel_cycles", psel_cnt - b_psel, 8);
    chk("t3_pen_cycles", pen_cnt - b_pen, 4);
    chk("t3_rsp_count", rsp_cnt - b_rsp, 4);
    $display("t3 contention grants=%0d", grants.size() - b_g);

    // Timeout on requester 0 while requester 1 is pending
    ws = 255; slave_rdata = 8'hC3;
    b_pen = pen_cnt;
    set_req(0, 1'b1, 4'h5, 8'h3C);
    set_req(1, 1'b0, 4'h9, 8'h00);
    wait_ready(0);
    wait_rsp(0, rd, er, ps);
    t_rsp = cyc;
    chk("t4_err", er, 1'b1);
    chk("t4_rdata", rd, 8'h00);
    chk("t4_psel_at_abort", ps, 1'b0);
    chk("t4_pen_cycles", pen_cnt - b_pen, TO);
    ws = 0;
    wait_ready(1);
    chk("t4_idle_gap", grant_cyc[$] - t_rsp, 1);
    wait_rsp(1, rd, er, ps);
    chk("t4_next_err", er, 1'b0);
    chk("t4_next_rdata", rd, 8'hC3);
    $display("t4 timeout then read rdata=%0h", rd);

    // Reset in the middle of ACCESS
    ws = 255;
    set_req(1, 1'b0, 4'h6, 8'h00);
    wait_ready(1);
    repeat (3) tick();
    b_rsp = rsp_cnt;
    PRESET = 1'b1;
    tick();
    chk("t5_psel", apb.PSELx, 1'b0);
    chk("t5_penable", apb.PENABLE, 1'b0);
    chk("t5_rsp", rsp_valid, 2'b00);
    PRESET = 1'b0;
    ws = 0;
    b_g = grants.size();
    set_req(0, 1'b0, 4'h2, 8'h00);
    set_req(1, 1'b0, 4'h4, 8'h00);
    wait_ready(0);
    chk("t5_first_ready", req_ready, 2'b01);
    wait_rsp(0, rd, er, ps);
    wait_ready(1);
    wait_rsp(1, rd, er, ps);
    chk("t5_rsp_count", rsp_cnt - b_rsp, 2);
    if (grants.size() > b_g) chk("t5_first_grant", grants[b_g], 0);
    $display("t5 reset mid-access recovered");

    // Idle hold after a write to address 7
    set_req(0, 1'b1, 4'h7, 8'h11);
    wait_ready(0);
    wait_rsp(0, rd, er, ps);
    tick();
    b_psel = psel_cnt; b_g = grants.size(); b_rsp = rsp_cnt;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t6_paddr_hold", apb.PADDR, 4'h7);
    end
    chk("t6_psel_cycles", psel_cnt - b_psel, 0);
    chk("t6_grants", grants.size() - b_g, 0);
    chk("t6_rsps", rsp_cnt - b_rsp, 0);
    $display("t6 idle hold paddr=%0h", apb.PADDR);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_bus_arbiter.md
Name: apb_bus_arbiter

Overview:
- Multi-requester APB master. Arbitrates round-robin between NUM_REQ local requesters and runs one APB transfer at a time (IDLE/SETUP/ACCESS) toward the existing APB slave.
- Returns read data, a completion pulse and an error flag to the granted requester.
- Sits between the internal requesters (CPU-side port, DMA-side port) and the shared APB slave bus.

Parameters:
- DATA_WIDTH, 8, APB data width; matches the slave.
- ADDR_WIDTH, 4, APB address width; matches the slave.
- NUM_REQ, 2, number of requesters; legal range 2..4.
- TIMEOUT, 15, maximum ACCESS cycles with PREADY low before the transfer is aborted; legal range 1..255.

Ports:
- PCLK  in  1  clock; all logic on its rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request; held until req_ready is seen.
- req_write  in  NUM_REQ  per-requester direction; 1 = write.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data; requester i uses slice i.
- req_ready  out  NUM_REQ  one-hot one-cycle accept pulse.
- rsp_valid  out  NUM_REQ  one-hot one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data for the completing transfer.
- rsp_err  out  1  timeout flag; qualified by rsp_valid.
- PSELx  out  1  APB select.
- PENABLE  out  1  APB enable.
- PADDR  out  ADDR_WIDTH  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.

Behaviour:
- Reset (PRESET high at an edge):
  - state = IDLE.
  - All outputs = 0.
  - Wait counter = 0.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 has top priority first.
  - Reset mid-transfer abandons the transfer: no rsp_valid is issued, and PSELx/PENABLE are low in the cycle after the edge.
- All outputs are registered.
- Arbitration:
  - Winner g = first i with req_valid[i], searching last+1, last+2, ... modulo NUM_REQ.
  - On grant: last <= g.
  - On grant: latch req_addr/req_write/req_wdata slice g into PADDR/PWRITE/PWDATA.
  - On grant: req_ready[g] = 1 for exactly one cycle.
  - Requester g drops or changes req_valid after seeing req_ready.
- IDLE:
  - PSELx = 0, PENABLE = 0.
  - If any req_valid: grant and go to SETUP.
  - Otherwise: stay in IDLE; PADDR/PWRITE/PWDATA hold their last values.
- SETUP:
  - PSELx = 1, PENABLE = 0.
  - Lasts exactly one cycle, then go to ACCESS.
  - req_valid is not sampled.
- ACCESS:
  - PSELx = 1, PENABLE = 1; PADDR/PWRITE/PWDATA stable.
  - PREADY low: increment the wait counter.
    - If the counter reaches TIMEOUT: abort and go to IDLE.
    - Abort: rsp_valid[g] = 1, rsp_err = 1, rsp_rdata = 0.
  - PREADY high: transfer completes.
    - Next cycle: rsp_valid[g] = 1, rsp_err = 0.
    - Next cycle, read: rsp_rdata = PRDATA sampled at that edge.
    - Next cycle, write: rsp_rdata = 0.
    - Wait counter cleared.
- Back-to-back:
  - At the completing edge, arbitration runs. If any req_valid, grant, go directly to SETUP; PSELx stays 1, PENABLE drops to 0.
  - Otherwise go to IDLE.
- Timeout does not grant in the same cycle; the state always passes through IDLE.
- Latency:
  - req_valid sampled at edge k gives PSELx and req_ready high after edge k, PENABLE high after k+1.
  - With zero wait states, rsp_valid is high after edge k+2.
  - Minimum APB transfer is 2 cycles; a 0-wait transfer occupies 3 cycles when it starts and ends in IDLE.
- Simultaneous events:
  - A requester that loses arbitration is served no later than after NUM_REQ-1 other grants.
  - req_valid asserted while the arbiter is busy waits; it is never dropped.
- PSELx and PENABLE never change while PREADY is low in ACCESS, except on timeout or reset.

Test Plan:
- Single write, requester 0: addr 4'h3, wdata 8'hA5, PREADY tied 1.
  - Response: req_ready[0] one cycle; PSELx 2 cycles, PENABLE 1 cycle; PADDR=3, PWRITE=1, PWDATA=A5.
  - Then rsp_valid[0]=1, rsp_err=0.
- Read with 2 wait states, requester 1: addr 4'h3, PREADY low 2 ACCESS cycles, then high with PRDATA=8'h5A.
  - Response: PENABLE high 3 cycles; rsp_valid[1]=1, rsp_rdata=8'h5A.
- Contention: both req_valid high continuously after reset, 4 transfers.
  - Response: grant order 0,1,0,1.
  - Each handover is back-to-back: PSELx stays 1 and PENABLE goes 1→0→1 between transfers.
- Timeout: TIMEOUT=15, PREADY held 0.
  - Response: after 15 ACCESS cycles, PSELx=0, rsp_valid[g]=1, rsp_err=1, rsp_rdata=0.
  - Next request completes normally.
- Reset mid-ACCESS: PRESET pulsed 1 cycle while PREADY is low.
  - Response: next cycle PSELx=0, PENABLE=0, no rsp_valid.
  - First grant afterwards goes to requester 0 when both request.
- Idle hold: no req_valid for 10 cycles after a write to 4'h7.
  - Response: PSELx=0 throughout; PADDR stays 4'h7; no req_ready or rsp_valid.
